// File: rtl/tdm_mux_scanner.sv
// Registered N:1 channel multiplexer with manual select and round-robin auto-scan.
// Emits one sample per visited channel on a valid/ready output that may stall.
module tdm_mux_scanner #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 16,
   parameter  int DWELL    = 1,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS-1:0]       ch_en,
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      wrap
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_EMIT} state_t;

   state_t            state_reg, state_next;
   logic [SEL_W-1:0]  ptr_reg, ptr_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [WIDTH-1:0]  out_reg;
   logic [SEL_W-1:0]  out_ch_reg;
   logic              out_valid_reg;
   logic              wrap_reg, wrap_next;

   logic [WIDTH-1:0]  chan [CHANNELS];
   logic [SEL_W-1:0]  first_ptr, adv_ptr, cap_ch;
   logic              slot_free, sel_ok, capture;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign chan[gi] = in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Channel index base+off, modulo CHANNELS (off never exceeds CHANNELS).
   function automatic logic [SEL_W-1:0] circ(input logic [SEL_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= CHANNELS) s = s - CHANNELS;
      return SEL_W'(s);
   endfunction

   assign slot_free = !out_valid_reg || out_ready;
   assign sel_ok    = (int'(sel) < CHANNELS);

   // Descending loops so the smallest circular offset wins.
   always_comb begin
      first_ptr = ptr_reg;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (ch_en[circ(ptr_reg, i)]) first_ptr = circ(ptr_reg, i);
   end

   always_comb begin
      adv_ptr = ptr_reg;
      for (int i = CHANNELS; i >= 1; i--)
         if (ch_en[circ(ptr_reg, i)]) adv_ptr = circ(ptr_reg, i);
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      wrap_next  = 1'b0;
      capture    = 1'b0;
      cap_ch     = ptr_reg;
      if (!mode || ch_en == '0) begin
         state_next = ST_IDLE;
         if (!mode && slot_free && sel_ok && ch_en[sel]) begin
            capture = 1'b1;
            cap_ch  = sel;
         end
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ptr_next   = first_ptr;
               cnt_next   = CNT_LOAD;
               state_next = (DWELL == 1) ? ST_EMIT : ST_DWELL;
            end
            ST_DWELL: begin
               cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
               if (cnt_reg <= CNT_W'(1)) state_next = ST_EMIT;
            end
            ST_EMIT: begin
               // A channel disabled while we dwelt on it is skipped without a sample.
               if (!ch_en[ptr_reg] || slot_free) begin
                  capture    = ch_en[ptr_reg];
                  ptr_next   = adv_ptr;
                  wrap_next  = (adv_ptr <= ptr_reg);
                  cnt_next   = CNT_LOAD;
                  state_next = (DWELL == 1) ? ST_EMIT : ST_DWELL;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         cnt_reg       <= '0;
         wrap_reg      <= 1'b0;
         out_reg       <= '0;
         out_ch_reg    <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         wrap_reg  <= wrap_next;
         if (capture) begin
            out_reg       <= chan[cap_ch];
            out_ch_reg    <= cap_ch;
            out_valid_reg <= 1'b1;
         end else if (slot_free) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out       = out_reg;
   assign out_ch    = out_ch_reg;
   assign out_valid = out_valid_reg;
   assign wrap      = wrap_reg;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Bench for tdm_mux_scanner: directed scenarios plus random traffic checked against
// a timer-based behavioural model of the scan rules.
module tb_tdm_mux_scanner;

   localparam int W   = 8;
   localparam int NCH = 16;
   localparam int DW  = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH*W-1:0] d_in;
   logic             mode;
   logic [3:0]       sel;
   logic [NCH-1:0]   ch_en;
   logic [W-1:0]     out;
   logic [3:0]       out_ch;
   logic             out_valid;
   logic             out_ready;
   logic             wrap;

   logic [15:0]      in1;
   logic             mode1;
   logic [3:0]       sel1;
   logic [15:0]      en1;
   logic [0:0]       out1;
   logic [3:0]       out_ch1;
   logic             valid1;
   logic             ready1;
   logic             wrap1;

   always #5 clk = ~clk;

   tdm_mux_scanner #(.WIDTH(W), .CHANNELS(NCH), .DWELL(DW)) dut (
      .clk(clk), .rst(rst), .in(d_in), .mode(mode), .sel(sel), .ch_en(ch_en),
      .out(out), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready), .wrap(wrap)
   );

   tdm_mux_scanner #(.WIDTH(1), .CHANNELS(16), .DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .in(in1), .mode(mode1), .sel(sel1), .ch_en(en1),
      .out(out1), .out_ch(out_ch1), .out_valid(valid1), .out_ready(ready1), .wrap(wrap1)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int tick_no = 0;

   // Behavioural model: scan position plus cycles left before the current channel may emit.
   logic [W-1:0] m_out;
   int           m_ch, m_ptr, m_timer;
   logic         m_valid, m_wrap, m_scan;

   logic hs;
   int   hs_ch;
   logic log_hs = 1'b0;
   int   hs_chs[$];
   int   hs_ticks[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
      end
   endtask

   function automatic int first_from(input int p);
      for (int i = 0; i < NCH; i++) if (ch_en[(p + i) % NCH]) return (p + i) % NCH;
      return p;
   endfunction

   function automatic int next_after(input int p);
      for (int i = 1; i <= NCH; i++) if (ch_en[(p + i) % NCH]) return (p + i) % NCH;
      return p;
   endfunction

   task automatic model_edge();
      logic free, cap;
      int   old;
      free   = !m_valid || out_ready;
      cap    = 1'b0;
      m_wrap = 1'b0;
      if (rst) begin
         m_out = '0; m_ch = 0; m_valid = 1'b0; m_scan = 1'b0; m_ptr = 0; m_timer = 0;
         return;
      end
      if (!mode || ch_en == '0) begin
         m_scan = 1'b0;
         if (!mode && free && ch_en[sel]) begin
            m_out = d_in[int'(sel)*W +: W]; m_ch = int'(sel); cap = 1'b1;
         end
      end else if (!m_scan) begin
         m_ptr = first_from(m_ptr); m_timer = DW - 1; m_scan = 1'b1;
      end else if (m_timer > 0) begin
         m_timer--;
      end else if (!ch_en[m_ptr] || free) begin
         if (ch_en[m_ptr]) begin
            m_out = d_in[m_ptr*W +: W]; m_ch = m_ptr; cap = 1'b1;
         end
         old = m_ptr; m_ptr = next_after(old); m_wrap = (m_ptr <= old); m_timer = DW - 1;
      end
      if (cap) m_valid = 1'b1;
      else if (free) m_valid = 1'b0;
   endtask

   task automatic tick();
      hs    = out_valid && out_ready;
      hs_ch = int'(out_ch);
      if (hs) $display("[TB] xfer ch=%0d data=%02h", out_ch, out);
      if (hs && log_hs) begin hs_chs.push_back(hs_ch); hs_ticks.push_back(tick_no + 1); end
      model_edge();
      @(posedge clk);
      @(negedge clk);
      tick_no++;
      check("out", out, m_out);
      check("out_ch", out_ch, m_ch);
      check("out_valid", out_valid, m_valid);
      check("wrap", wrap, m_wrap);
   endtask

   function automatic logic [NCH*W-1:0] rnd_in();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int first_t, exp_ch, held_ch;
      logic [W-1:0] held;
      logic found;
      int seq[3] = '{0, 2, 9};
      logic [15:0] fac7 = 16'hFAC7;

      rst = 1'b1; mode = 1'b1; sel = '0; ch_en = '1; out_ready = 1'b1;
      d_in = rnd_in() | 128'h1;
      in1 = fac7; mode1 = 1'b1; sel1 = '0; en1 = 16'hFFFF; ready1 = 1'b1;
      m_out = '0; m_ch = 0; m_valid = 1'b0; m_wrap = 1'b0; m_scan = 1'b0; m_ptr = 0; m_timer = 0;
      @(negedge clk);

      // Reset held for 3 cycles with nonzero inputs and scan requested
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_out1", out1, 0);
         check("rst_valid1", valid1, 0);
         check("rst_wrap1", wrap1, 0);
      end
      rst = 1'b0;

      // Scan ordering on the 1-bit instance, first-sample latency on the main one
      first_t = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (out_valid && first_t == 0) first_t = t;
         if (t == 1) begin
            check("scan1_first_valid", valid1, 0);
         end else begin
            exp_ch = (t - 2) % 16;
            check("scan1_valid", valid1, 1);
            check("scan1_ch", out_ch1, exp_ch);
            check("scan1_out", out1, fac7[exp_ch]);
            check("scan1_wrap", wrap1, (exp_ch == 15));
         end
      end
      check("first_sample_tick", first_t, DW + 1);
      mode1 = 1'b0;

      // Mask 0,2,9 with dwell 3, then a stall
      rst = 1'b1; tick(); rst = 1'b0;
      ch_en = 16'h0205; mode = 1'b1; out_ready = 1'b1;
      log_hs = 1'b1; hs_chs.delete(); hs_ticks.delete();
      for (int i = 0; i < 11; i++) begin d_in = rnd_in(); tick(); end
      out_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin d_in = rnd_in(); tick(); found = out_valid; end
      check("stall_wait_valid", found, 1);
      held = out; held_ch = int'(out_ch);
      for (int i = 0; i < 5; i++) begin
         d_in = rnd_in(); tick();
         check("stall_out", out, held);
         check("stall_ch", out_ch, held_ch);
         check("stall_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin d_in = rnd_in(); tick(); end
      log_hs = 1'b0;
      check("mask_count", (hs_chs.size() >= 8), 1);
      foreach (hs_chs[k]) check("mask_seq", hs_chs[k], seq[k % 3]);
      if (hs_ticks.size() >= 3) begin
         check("mask_gap0", hs_ticks[1] - hs_ticks[0], DW);
         check("mask_gap1", hs_ticks[2] - hs_ticks[1], DW);
      end

      // Manual mode
      mode = 1'b0; ch_en = '1;
      for (int s = 0; s < 16; s++) begin
         logic [NCH*W-1:0] prev_in;
         sel = 4'(s); d_in = rnd_in(); prev_in = d_in;
         tick();
         check("man_out", out, prev_in[s*W +: W]);
         check("man_ch", out_ch, s);
      end
      sel = 4'd3; ch_en = 16'hFFF7;
      tick();
      check("man_disabled_valid", out_valid, 0);

      // Mode switch mid-scan: resume at the channel after 5
      rst = 1'b1; tick(); rst = 1'b0;
      ch_en = '1; mode = 1'b1; out_ready = 1'b1; sel = 4'd12;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         d_in = rnd_in(); tick(); found = out_valid && out_ch == 4'd5;
      end
      check("wait_ch5", found, 1);
      mode = 1'b0;
      for (int i = 0; i < 4; i++) begin d_in = rnd_in(); tick(); end
      mode = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         d_in = rnd_in(); tick(); found = out_valid && out_ch != 4'd12;
      end
      check("resume_found", found, 1);
      check("resume_ch", out_ch, 6);

      // Empty mask while a sample is pending
      out_ready = 1'b0;
      found = out_valid;
      for (int i = 0; i < 10 && !found; i++) begin d_in = rnd_in(); tick(); found = out_valid; end
      check("empty_wait_valid", found, 1);
      ch_en = '0;
      for (int i = 0; i < 3; i++) begin tick(); check("empty_pending", out_valid, 1); end
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         d_in = rnd_in(); tick();
         check("empty_valid", out_valid, 0);
         check("empty_wrap", wrap, 0);
      end
      ch_en = '1;

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         d_in      = rnd_in();
         out_ready = ($urandom_range(3) != 0);
         sel       = 4'($urandom_range(15));
         rst       = ($urandom_range(99) == 0);
         if ($urandom_range(19) == 0) mode = ~mode;
         case ($urandom_range(15))
            0: ch_en = '0;
            1: ch_en = NCH'(1) << $urandom_range(NCH - 1);
            2: ch_en = NCH'($urandom);
            3: ch_en = '1;
            default: ;
         endcase
         tick();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
